// File: rtl/pcie_tlp_responder_if.sv
// AXI-Stream request (RX) and completion (TX) bundle between the PCIe core wrapper and the responder.
// master = core wrapper side, slave = responder side.
interface pcie_tlp_responder_if;
  logic [63:0] m_axis_rx_tdata;
  logic [7:0]  m_axis_rx_tkeep;
  logic        m_axis_rx_tlast;
  logic        m_axis_rx_tvalid;
  logic [21:0] m_axis_rx_tuser;
  logic        m_axis_rx_tready;
  logic [63:0] s_axis_tx_tdata;
  logic [7:0]  s_axis_tx_tkeep;
  logic        s_axis_tx_tlast;
  logic        s_axis_tx_tvalid;
  logic [3:0]  s_axis_tx_tuser;
  logic        s_axis_tx_tready;

  modport master (
    output m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid, m_axis_rx_tuser,
    input  m_axis_rx_tready,
    input  s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tvalid, s_axis_tx_tuser,
    output s_axis_tx_tready
  );

  modport slave (
    input  m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid, m_axis_rx_tuser,
    output m_axis_rx_tready,
    output s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tlast, s_axis_tx_tvalid, s_axis_tx_tuser,
    input  s_axis_tx_tready
  );
endinterface

// File: rtl/pcie_tlp_responder.sv
// BAR0 target completer: single-DW MRd32/MWr32 to register-port accesses, CplD for reads.
// Optional PCIE_RESP_UR_CPL_EN: unsupported non-posted requests also get a UR Cpl.
module pcie_tlp_responder #(
  parameter int unsigned REG_AW = 10
) (
  input  logic                  user_clk,
  input  logic                  sys_rst_n,
  pcie_tlp_responder_if.slave   axis,
  input  logic [15:0]           cfg_completer_id,
  output logic [REG_AW-1:0]     reg_addr,
  output logic                  reg_wr_en,
  output logic [31:0]           reg_wr_data,
  output logic [3:0]            reg_wr_be,
  output logic                  reg_rd_en,
  input  logic [31:0]           reg_rd_data,
  output logic                  cfg_err_ur,
  output logic                  cfg_trn_pending
);

  typedef enum logic [2:0] {IDLE, HDR2, DRAIN, RDW, TX0, TX1} state_t;

  state_t state_q, state_d;
  logic        rd_phase_q, rd_phase_d;
  logic [1:0]  fmt_q, fmt_d;
  logic [4:0]  type_q, type_d;
  logic [2:0]  tc_q, tc_d;
  logic [1:0]  attr_q, attr_d;
  logic [9:0]  len_q, len_d;
  logic [15:0] req_id_q, req_id_d;
  logic [7:0]  tag_q, tag_d;
  logic [3:0]  be_q, be_d;
  logic        bar0_q, bar0_d;
  logic [4:0]  lo_addr_q, lo_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        ur_cpl_q, ur_cpl_d;

  logic              rx_tready_q, rx_tready_d;
  logic [63:0]       tx_tdata_q, tx_tdata_d;
  logic [7:0]        tx_tkeep_q, tx_tkeep_d;
  logic              tx_tlast_q, tx_tlast_d;
  logic              tx_tvalid_q, tx_tvalid_d;
  logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
  logic              reg_wr_en_q, reg_wr_en_d;
  logic [31:0]       reg_wr_data_q, reg_wr_data_d;
  logic [3:0]        reg_wr_be_q, reg_wr_be_d;
  logic              reg_rd_en_q, reg_rd_en_d;
  logic              cfg_err_ur_q, cfg_err_ur_d;
  logic              pending_q, pending_d;

  logic        rx_fire;
  logic        tx_fire;
  logic        sup_wr;
  logic        sup_rd;
  logic [31:0] cpl_dw0;
  logic [31:0] cpl_dw1;
  logic [31:0] cpl_dw2;
  logic        unused_ok;

  assign rx_fire = axis.m_axis_rx_tvalid & rx_tready_q;
  assign tx_fire = axis.s_axis_tx_tready & tx_tvalid_q;
  assign sup_wr  = bar0_q && (type_q == 5'b00000) && (len_q == 10'd1) && (fmt_q == 2'b10);
  assign sup_rd  = bar0_q && (type_q == 5'b00000) && (len_q == 10'd1) && (fmt_q == 2'b00);

`ifdef PCIE_RESP_UR_CPL_EN
  logic np_req;
  // Non-posted: any MRd/MRdLk (3DW or 4DW), IO read, Cfg type 0/1 read.
  assign np_req = !fmt_q[1] && ((type_q[4:1] == 4'b0000) || (type_q == 5'b00010) ||
                                (type_q[4:1] == 4'b0010));
`endif

  // Completion header; UR variant carries no data and status 001.
  assign cpl_dw0 = (ur_cpl_q ? 32'h0A00_0000 : 32'h4A00_0001) |
                   {9'd0, tc_q, 6'd0, attr_q, 12'd0};
  assign cpl_dw1 = {cfg_completer_id, (ur_cpl_q ? 3'b001 : 3'b000), 1'b0, 12'd4};
  assign cpl_dw2 = {req_id_q, tag_q, 1'b0, lo_addr_q, 2'b00};

  always_ff @(posedge user_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      rd_phase_q    <= 1'b0;
      fmt_q         <= '0;
      type_q        <= '0;
      tc_q          <= '0;
      attr_q        <= '0;
      len_q         <= '0;
      req_id_q      <= '0;
      tag_q         <= '0;
      be_q          <= '0;
      bar0_q        <= 1'b0;
      lo_addr_q     <= '0;
      rd_data_q     <= '0;
      ur_cpl_q      <= 1'b0;
      rx_tready_q   <= 1'b1;
      tx_tdata_q    <= '0;
      tx_tkeep_q    <= '0;
      tx_tlast_q    <= 1'b0;
      tx_tvalid_q   <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_data_q <= '0;
      reg_wr_be_q   <= '0;
      reg_rd_en_q   <= 1'b0;
      cfg_err_ur_q  <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_phase_q    <= rd_phase_d;
      fmt_q         <= fmt_d;
      type_q        <= type_d;
      tc_q          <= tc_d;
      attr_q        <= attr_d;
      len_q         <= len_d;
      req_id_q      <= req_id_d;
      tag_q         <= tag_d;
      be_q          <= be_d;
      bar0_q        <= bar0_d;
      lo_addr_q     <= lo_addr_d;
      rd_data_q     <= rd_data_d;
      ur_cpl_q      <= ur_cpl_d;
      rx_tready_q   <= rx_tready_d;
      tx_tdata_q    <= tx_tdata_d;
      tx_tkeep_q    <= tx_tkeep_d;
      tx_tlast_q    <= tx_tlast_d;
      tx_tvalid_q   <= tx_tvalid_d;
      reg_addr_q    <= reg_addr_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_data_q <= reg_wr_data_d;
      reg_wr_be_q   <= reg_wr_be_d;
      reg_rd_en_q   <= reg_rd_en_d;
      cfg_err_ur_q  <= cfg_err_ur_d;
      pending_q     <= pending_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rd_phase_d    = 1'b0;
    fmt_d         = fmt_q;
    type_d        = type_q;
    tc_d          = tc_q;
    attr_d        = attr_q;
    len_d         = len_q;
    req_id_d      = req_id_q;
    tag_d         = tag_q;
    be_d          = be_q;
    bar0_d        = bar0_q;
    lo_addr_d     = lo_addr_q;
    rd_data_d     = rd_data_q;
    ur_cpl_d      = ur_cpl_q;
    tx_tdata_d    = tx_tdata_q;
    tx_tkeep_d    = tx_tkeep_q;
    tx_tlast_d    = tx_tlast_q;
    tx_tvalid_d   = tx_tvalid_q;
    reg_addr_d    = reg_addr_q;
    reg_wr_en_d   = 1'b0;
    reg_wr_data_d = reg_wr_data_q;
    reg_wr_be_d   = reg_wr_be_q;
    reg_rd_en_d   = 1'b0;
    cfg_err_ur_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          fmt_d    = axis.m_axis_rx_tdata[30:29];
          type_d   = axis.m_axis_rx_tdata[28:24];
          tc_d     = axis.m_axis_rx_tdata[22:20];
          attr_d   = axis.m_axis_rx_tdata[13:12];
          len_d    = axis.m_axis_rx_tdata[9:0];
          req_id_d = axis.m_axis_rx_tdata[63:48];
          tag_d    = axis.m_axis_rx_tdata[47:40];
          be_d     = axis.m_axis_rx_tdata[35:32];
          bar0_d   = axis.m_axis_rx_tuser[2];
          // A one-beat TLP cannot be a 3DW request; reject it without leaving IDLE.
          if (axis.m_axis_rx_tlast) cfg_err_ur_d = 1'b1;
          else                      state_d      = HDR2;
        end
      end
      HDR2: begin
        if (rx_fire) begin
          lo_addr_d = axis.m_axis_rx_tdata[6:2];
          ur_cpl_d  = 1'b0;
          if (sup_wr) begin
            reg_wr_en_d   = 1'b1;
            reg_addr_d    = axis.m_axis_rx_tdata[REG_AW+1:2];
            reg_wr_data_d = axis.m_axis_rx_tdata[63:32];
            reg_wr_be_d   = be_q;
            state_d       = axis.m_axis_rx_tlast ? IDLE : DRAIN;
          end else if (sup_rd) begin
            reg_rd_en_d = 1'b1;
            reg_addr_d  = axis.m_axis_rx_tdata[REG_AW+1:2];
            state_d     = RDW;
          end else begin
            cfg_err_ur_d = 1'b1;
`ifdef PCIE_RESP_UR_CPL_EN
            ur_cpl_d = np_req;
            if (!axis.m_axis_rx_tlast) state_d = DRAIN;
            else                       state_d = np_req ? RDW : IDLE;
`else
            state_d = axis.m_axis_rx_tlast ? IDLE : DRAIN;
`endif
          end
        end
      end
      DRAIN: begin
        if (rx_fire && axis.m_axis_rx_tlast) state_d = ur_cpl_q ? RDW : IDLE;
      end
      RDW: begin
        // First cycle is the strobe cycle; read data is valid on the second.
        if (!rd_phase_q) begin
          rd_phase_d = 1'b1;
        end else begin
          rd_data_d   = ur_cpl_q ? 32'd0 : reg_rd_data;
          tx_tdata_d  = {cpl_dw1, cpl_dw0};
          tx_tkeep_d  = 8'hFF;
          tx_tlast_d  = 1'b0;
          tx_tvalid_d = 1'b1;
          state_d     = TX0;
        end
      end
      TX0: begin
        if (tx_fire) begin
          tx_tdata_d = {rd_data_q, cpl_dw2};
          tx_tkeep_d = ur_cpl_q ? 8'h0F : 8'hFF;
          tx_tlast_d = 1'b1;
          state_d    = TX1;
        end
      end
      TX1: begin
        if (tx_fire) begin
          tx_tdata_d  = '0;
          tx_tkeep_d  = '0;
          tx_tlast_d  = 1'b0;
          tx_tvalid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rx_tready_d = (state_d == IDLE) || (state_d == HDR2) || (state_d == DRAIN);
    pending_d   = (state_d == RDW) || (state_d == TX0) || (state_d == TX1);
  end

  assign axis.m_axis_rx_tready = rx_tready_q;
  assign axis.s_axis_tx_tdata  = tx_tdata_q;
  assign axis.s_axis_tx_tkeep  = tx_tkeep_q;
  assign axis.s_axis_tx_tlast  = tx_tlast_q;
  assign axis.s_axis_tx_tvalid = tx_tvalid_q;
  assign axis.s_axis_tx_tuser  = 4'b0000;

  assign reg_addr        = reg_addr_q;
  assign reg_wr_en       = reg_wr_en_q;
  assign reg_wr_data     = reg_wr_data_q;
  assign reg_wr_be       = reg_wr_be_q;
  assign reg_rd_en       = reg_rd_en_q;
  assign cfg_err_ur      = cfg_err_ur_q;
  assign cfg_trn_pending = pending_q;

  // Header/keep/tuser bits that carry nothing for single-DW BAR0 traffic.
  assign unused_ok = ^{axis.m_axis_rx_tkeep, axis.m_axis_rx_tuser, axis.m_axis_rx_tdata};

endmodule

// File: tb/tb_pcie_tlp_responder.sv
// Directed bench for pcie_tlp_responder: MWr/MRd, backpressure, UR handling, mid-TLP reset.
module tb_pcie_tlp_responder;

  logic        user_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] cfg_completer_id;
  logic [9:0]  reg_addr;
  logic        reg_wr_en;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_be;
  logic        reg_rd_en;
  logic [31:0] reg_rd_data;
  logic        cfg_err_ur;
  logic        cfg_trn_pending;
  int          total;
  int          bad;

  always #5 user_clk = ~user_clk;

  pcie_tlp_responder_if axis ();

  pcie_tlp_responder #(.REG_AW(10)) dut (
    .user_clk        (user_clk),
    .sys_rst_n       (sys_rst_n),
    .axis            (axis),
    .cfg_completer_id(cfg_completer_id),
    .reg_addr        (reg_addr),
    .reg_wr_en       (reg_wr_en),
    .reg_wr_data     (reg_wr_data),
    .reg_wr_be       (reg_wr_be),
    .reg_rd_en       (reg_rd_en),
    .reg_rd_data     (reg_rd_data),
    .cfg_err_ur      (cfg_err_ur),
    .cfg_trn_pending (cfg_trn_pending)
  );

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present one RX beat, wait (bounded) for tready, and let it be accepted.
  task automatic send_beat(input logic [63:0] d, input logic last, input logic bar);
    int n;
    axis.m_axis_rx_tdata  = d;
    axis.m_axis_rx_tkeep  = 8'hFF;
    axis.m_axis_rx_tlast  = last;
    axis.m_axis_rx_tvalid = 1'b1;
    axis.m_axis_rx_tuser  = {19'd0, bar, 2'b00};
    n = 0;
    while (axis.m_axis_rx_tready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk1("rx_tready_wait", axis.m_axis_rx_tready, 1'b1);
    step();
    axis.m_axis_rx_tvalid = 1'b0;
    axis.m_axis_rx_tlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    axis.m_axis_rx_tdata  = '0;
    axis.m_axis_rx_tkeep  = '0;
    axis.m_axis_rx_tlast  = 1'b0;
    axis.m_axis_rx_tvalid = 1'b0;
    axis.m_axis_rx_tuser  = '0;
    axis.s_axis_tx_tready = 1'b1;
    cfg_completer_id      = 16'h0200;
    reg_rd_data           = 32'h1234_5678;
    repeat (3) step();

    // Reset values
    chk1("rst_rx_tready", axis.m_axis_rx_tready, 1'b1);
    chk1("rst_tx_tvalid", axis.s_axis_tx_tvalid, 1'b0);
    chkw("rst_tx_tdata", axis.s_axis_tx_tdata, 64'h0);
    chkw("rst_tx_tuser", 64'(axis.s_axis_tx_tuser), 64'h0);
    chk1("rst_wr_en", reg_wr_en, 1'b0);
    chk1("rst_rd_en", reg_rd_en, 1'b0);
    chk1("rst_err_ur", cfg_err_ur, 1'b0);
    chk1("rst_pending", cfg_trn_pending, 1'b0);
    sys_rst_n = 1'b1;
    step();

    // MWr32 0x10 <= 0xDEADBEEF, BE=F
    send_beat(64'h0100_010F_4000_0001, 1'b0, 1'b1);
    send_beat(64'hDEAD_BEEF_0000_0010, 1'b1, 1'b1);
    chk1("mwr_wr_en", reg_wr_en, 1'b1);
    chkw("mwr_addr", 64'(reg_addr), 64'd4);
    chkw("mwr_data", 64'(reg_wr_data), 64'hDEAD_BEEF);
    chkw("mwr_be", 64'(reg_wr_be), 64'hF);
    chk1("mwr_no_rd", reg_rd_en, 1'b0);
    step();
    chk1("mwr_pulse", reg_wr_en, 1'b0);
    chk1("mwr_tx_idle", axis.s_axis_tx_tvalid, 1'b0);
    chk1("mwr_rx_ready", axis.m_axis_rx_tready, 1'b1);

    // MRd32 0x24, req 0x0100 tag 0x07
    send_beat(64'h0100_070F_0000_0001, 1'b0, 1'b1);
    send_beat(64'h0000_0000_0000_0024, 1'b1, 1'b1);
    chk1("mrd_rd_en", reg_rd_en, 1'b1);
    chkw("mrd_addr", 64'(reg_addr), 64'd9);
    chk1("mrd_pending", cfg_trn_pending, 1'b1);
    chk1("mrd_rx_blocked", axis.m_axis_rx_tready, 1'b0);
    step();
    chk1("mrd_rd_pulse", reg_rd_en, 1'b0);
    chk1("mrd_tx_early", axis.s_axis_tx_tvalid, 1'b0);
    step();
    chk1("mrd_tx0_valid", axis.s_axis_tx_tvalid, 1'b1);
    chkw("mrd_tx0_data", axis.s_axis_tx_tdata, 64'h0200_0004_4A00_0001);
    chkw("mrd_tx0_keep", 64'(axis.s_axis_tx_tkeep), 64'hFF);
    chk1("mrd_tx0_last", axis.s_axis_tx_tlast, 1'b0);
    step();
    chkw("mrd_tx1_data", axis.s_axis_tx_tdata, 64'h1234_5678_0100_0724);
    chkw("mrd_tx1_keep", 64'(axis.s_axis_tx_tkeep), 64'hFF);
    chk1("mrd_tx1_last", axis.s_axis_tx_tlast, 1'b1);
    chk1("mrd_tx1_valid", axis.s_axis_tx_tvalid, 1'b1);
    step();
    chk1("mrd_done_valid", axis.s_axis_tx_tvalid, 1'b0);
    chk1("mrd_done_rx_ready", axis.m_axis_rx_tready, 1'b1);
    chk1("mrd_done_pending", cfg_trn_pending, 1'b0);

    // Same MRd with TX backpressure: 3 cycles in TX0, 2 in TX1
    axis.s_axis_tx_tready = 1'b0;
    send_beat(64'h0100_070F_0000_0001, 1'b0, 1'b1);
    send_beat(64'h0000_0000_0000_0024, 1'b1, 1'b1);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      chkw("bp_tx0_hold", axis.s_axis_tx_tdata, 64'h0200_0004_4A00_0001);
      chk1("bp_tx0_valid", axis.s_axis_tx_tvalid, 1'b1);
      chk1("bp_tx0_last", axis.s_axis_tx_tlast, 1'b0);
      chk1("bp_tx0_rx_blocked", axis.m_axis_rx_tready, 1'b0);
      chk1("bp_tx0_pending", cfg_trn_pending, 1'b1);
      step();
    end
    chkw("bp_tx0_hold_end", axis.s_axis_tx_tdata, 64'h0200_0004_4A00_0001);
    axis.s_axis_tx_tready = 1'b1;
    step();
    axis.s_axis_tx_tready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chkw("bp_tx1_hold", axis.s_axis_tx_tdata, 64'h1234_5678_0100_0724);
      chk1("bp_tx1_last", axis.s_axis_tx_tlast, 1'b1);
      chkw("bp_tx1_keep", 64'(axis.s_axis_tx_tkeep), 64'hFF);
      chk1("bp_tx1_rx_blocked", axis.m_axis_rx_tready, 1'b0);
      chk1("bp_tx1_pending", cfg_trn_pending, 1'b1);
      step();
    end
    chk1("bp_tx1_pending_end", cfg_trn_pending, 1'b1);
    axis.s_axis_tx_tready = 1'b1;
    step();
    chk1("bp_done_pending", cfg_trn_pending, 1'b0);
    chk1("bp_done_valid", axis.s_axis_tx_tvalid, 1'b0);
    chk1("bp_done_rx_ready", axis.m_axis_rx_tready, 1'b1);

    // MRd with length=2 -> UR
    send_beat(64'h0100_080F_0000_0002, 1'b0, 1'b1);
    send_beat(64'h0000_0000_0000_0024, 1'b1, 1'b1);
    chk1("ur_len_err", cfg_err_ur, 1'b1);
    chk1("ur_len_no_rd", reg_rd_en, 1'b0);
    step();
    chk1("ur_len_pulse", cfg_err_ur, 1'b0);
`ifdef PCIE_RESP_UR_CPL_EN
    chk1("ur_cpl_pending", cfg_trn_pending, 1'b1);
    step();
    chkw("ur_cpl_tx0", axis.s_axis_tx_tdata, 64'h0200_2004_0A00_0000);
    chk1("ur_cpl_tx0_valid", axis.s_axis_tx_tvalid, 1'b1);
    step();
    chkw("ur_cpl_tx1", axis.s_axis_tx_tdata, 64'h0000_0000_0100_0824);
    chkw("ur_cpl_tx1_keep", 64'(axis.s_axis_tx_tkeep), 64'h0F);
    chk1("ur_cpl_tx1_last", axis.s_axis_tx_tlast, 1'b1);
    step();
`endif
    chk1("ur_len_tx_idle", axis.s_axis_tx_tvalid, 1'b0);
    chk1("ur_len_rx_ready", axis.m_axis_rx_tready, 1'b1);
    chk1("ur_len_pending", cfg_trn_pending, 1'b0);

    // 4-beat MWr (length=4) -> UR, remaining beats drained
    send_beat(64'h0100_090F_4000_0004, 1'b0, 1'b1);
    send_beat(64'h1111_1111_0000_0030, 1'b0, 1'b1);
    chk1("ur_mwr_err", cfg_err_ur, 1'b1);
    chk1("ur_mwr_no_wr", reg_wr_en, 1'b0);
    send_beat(64'h2222_2222_3333_3333, 1'b0, 1'b1);
    chk1("ur_mwr_once", cfg_err_ur, 1'b0);
    chk1("ur_mwr_drain_rdy", axis.m_axis_rx_tready, 1'b1);
    send_beat(64'h4444_4444_5555_5555, 1'b1, 1'b1);
    chk1("ur_mwr_no_wr_end", reg_wr_en, 1'b0);
    chk1("ur_mwr_no_err_end", cfg_err_ur, 1'b0);

    // Good MWr right after drain; high address bits alias into the window
    send_beat(64'h0100_0A03_4000_0001, 1'b0, 1'b1);
    send_beat(64'hCAFE_F00D_FFFF_F008, 1'b1, 1'b1);
    chk1("alias_wr_en", reg_wr_en, 1'b1);
    chkw("alias_addr", 64'(reg_addr), 64'd2);
    chkw("alias_be", 64'(reg_wr_be), 64'h3);
    chkw("alias_data", 64'(reg_wr_data), 64'hCAFE_F00D);
    step();

    // MRd without BAR0 hit -> UR, no read strobe
    send_beat(64'h0100_0B0F_0000_0001, 1'b0, 1'b0);
    send_beat(64'h0000_0000_0000_0024, 1'b1, 1'b0);
    chk1("nobar_err", cfg_err_ur, 1'b1);
    chk1("nobar_no_rd", reg_rd_en, 1'b0);
    step();
    chk1("nobar_no_rd_late", reg_rd_en, 1'b0);
`ifdef PCIE_RESP_UR_CPL_EN
    repeat (3) step();
`endif
    chk1("nobar_tx_idle", axis.s_axis_tx_tvalid, 1'b0);
    chk1("nobar_rx_ready", axis.m_axis_rx_tready, 1'b1);

    // Reset asserted during TX1
    send_beat(64'h0100_070F_0000_0001, 1'b0, 1'b1);
    send_beat(64'h0000_0000_0000_0024, 1'b1, 1'b1);
    repeat (3) step();
    chk1("rst_pre_tx1_last", axis.s_axis_tx_tlast, 1'b1);
    sys_rst_n = 1'b0;
    #1;
    chk1("rst_mid_valid", axis.s_axis_tx_tvalid, 1'b0);
    chk1("rst_mid_last", axis.s_axis_tx_tlast, 1'b0);
    chkw("rst_mid_data", axis.s_axis_tx_tdata, 64'h0);
    chkw("rst_mid_keep", 64'(axis.s_axis_tx_tkeep), 64'h0);
    chk1("rst_mid_rx_ready", axis.m_axis_rx_tready, 1'b1);
    chk1("rst_mid_pending", cfg_trn_pending, 1'b0);
    step();
    sys_rst_n = 1'b1;
    step();

    // MRd after reset with a gap between beats, TC=3 attr=2, addr 0x7C
    reg_rd_data = 32'hA5A5_0F0F;
    send_beat(64'h0100_0C0F_0030_2001, 1'b0, 1'b1);
    step();
    step();
    chk1("gap_no_rd", reg_rd_en, 1'b0);
    chk1("gap_rx_ready", axis.m_axis_rx_tready, 1'b1);
    send_beat(64'h0000_0000_0000_007C, 1'b1, 1'b1);
    chk1("post_rst_rd_en", reg_rd_en, 1'b1);
    chkw("post_rst_addr", 64'(reg_addr), 64'h1F);
    step();
    step();
    chkw("post_rst_tx0", axis.s_axis_tx_tdata, 64'h0200_0004_4A30_2001);
    step();
    chkw("post_rst_tx1", axis.s_axis_tx_tdata, 64'hA5A5_0F0F_0100_0C7C);
    chk1("post_rst_tx1_last", axis.s_axis_tx_tlast, 1'b1);
    step();
    chk1("post_rst_done", axis.s_axis_tx_tvalid, 1'b0);
    chk1("post_rst_rx_ready", axis.m_axis_rx_tready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcie_tlp_responder.md
# pcie_tlp_responder

Target-side TLP completer on the 64-bit AXI-Stream user interface of the 4-lane Artix-7 PCIe endpoint. Parses single-DW memory requests from `m_axis_rx_*` and turns them into register-port accesses. For each read it returns a single-DW CplD on `s_axis_tx_*`. It is the responder for host-initiated BAR0 accesses and sits between the PCIe core wrapper and the coprocessor register file.

## Interface
- `REG_AW`, 10: DW address width of the register port; BAR0 window is 4·2^REG_AW bytes.
- `user_clk`  in  1  core user clock; all logic on rising edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `m_axis_rx_tdata`  in  64  request beat data.
- `m_axis_rx_tkeep`  in  8  request byte enables.
- `m_axis_rx_tlast`  in  1  last beat of the request TLP.
- `m_axis_rx_tvalid`  in  1  request beat valid.
- `m_axis_rx_tuser`  in  22  [2] = BAR0 hit.
- `m_axis_rx_tready`  out  1  request beat accepted.
- `s_axis_tx_tdata`  out  64  completion beat data.
- `s_axis_tx_tkeep`  out  8  completion byte enables.
- `s_axis_tx_tlast`  out  1  last completion beat.
- `s_axis_tx_tvalid`  out  1  completion beat valid.
- `s_axis_tx_tuser`  out  4  tied 4'b0000.
- `s_axis_tx_tready`  in  1  core accepts completion beat.
- `cfg_completer_id`  in  16  {bus, device, function}.
- `reg_addr`  out  REG_AW  DW address (request addr[REG_AW+1:2]).
- `reg_wr_en`  out  1  one-cycle write strobe.
- `reg_wr_data`  out  32  write data.
- `reg_wr_be`  out  4  first-DW byte enables.
- `reg_rd_en`  out  1  one-cycle read strobe.
- `reg_rd_data`  in  32  read data, valid the cycle after `reg_rd_en`.
- `cfg_err_ur`  out  1  one-cycle pulse per unsupported request.
- `cfg_trn_pending`  out  1  high while a read completion is outstanding.

## Operation
- Beat 0 carries DW0 in `[31:0]` and DW1 in `[63:32]`. Beat 1 carries DW2 (address) in `[31:0]` and write data in `[63:32]`.
- Supported request: 3DW MRd32 (fmt=00, type=00000) or MWr32 (fmt=10, type=00000), length=1, BAR0 hit. Every other TLP is unsupported.
- FSM states:
  - IDLE: `m_axis_rx_tready`=1. On a valid beat 0, latch DW0/DW1 and go to HDR2.
  - HDR2: latch beat 1.
    - Supported MWr: `reg_wr_en` pulses; go to IDLE (or DRAIN if tlast=0).
    - Supported MRd: `reg_rd_en` pulses; go to RDW.
    - Unsupported: `cfg_err_ur` pulses; go to DRAIN if tlast=0, else IDLE.
  - DRAIN: accept and discard beats until tlast, then go to IDLE.
  - RDW: `m_axis_rx_tready`=0. Capture `reg_rd_data`; go to TX0.
  - TX0: present beat 0 until `s_axis_tx_tready`, then go to TX1.
  - TX1: present beat 1 until `s_axis_tx_tready`, then go to IDLE.
- `m_axis_rx_tready`=0 in RDW, TX0 and TX1. Only one read is outstanding at a time.
- CplD fields:
  - DW0 = 0x4A000001 with TC[22:20] and attr[13:12] copied from the request.
  - DW1 = {`cfg_completer_id`, status 000, BCM 0, byte count 12'd4}.
  - DW2 = {requester ID, tag, 1'b0, lower address = {addr[6:2], 2'b00}}.
  - DW3 = read data.
  - Beat 0 = {DW1, DW0}, `tkeep`=0xFF. Beat 1 = {DW3, DW2}, `tkeep`=0xFF, `tlast`=1.
- Address bits above REG_AW+1 are ignored; addresses alias within the window.

## Timing
- Reset values: every output 0 except `m_axis_rx_tready`=1, and `s_axis_tx_tuser` fixed at 0. FSM resets to IDLE.
- Write latency: `reg_wr_en` asserts the cycle after beat 1 is accepted.
- Read latency: `reg_rd_en` asserts 1 cycle after beat 1 is accepted. TX0 `tvalid` asserts 2 cycles after `reg_rd_en`.
- With `s_axis_tx_tready` held high, MRd accept to TX tlast takes 5 cycles, and the next request can be accepted on the cycle after tlast.
- TX data, keep and last hold stable while tvalid=1 and tready=0.
- `cfg_trn_pending` is high from the `reg_rd_en` cycle through TX1 acceptance.
- A reset asserted mid-TLP aborts the FSM to IDLE immediately. The partial completion is lost and no strobes are issued.
- RX tvalid=0 between beat 0 and beat 1: stay in HDR2 with no strobe.

## Configuration
- `PCIE_RESP_UR_CPL_EN` defined: an unsupported non-posted request (MRd of any form, or IO/Cfg reads) additionally returns a Cpl, using the same RDW/TX0/TX1 path:
  - Cpl fields: DW0 fmt=00, type=01010, length=0; status=001 (UR).
  - Beat 1 `tkeep`=0x0F.
  - `cfg_err_ur` still pulses.
- Not defined: unsupported requests are dropped after the `cfg_err_ur` pulse and no completion is sent.

## Test plan
- MWr32 to 0x0000_0010 with data 0xDEADBEEF, BE=0xF, BAR0 hit → one-cycle `reg_wr_en`, `reg_addr`=4, `reg_wr_data`=0xDEADBEEF; TX stays idle.
- MRd32 to 0x24, requester 0x0100, tag 0x07, with `reg_rd_data`=0x12345678 and completer ID 0x0200 → beat 0 = 0x0200_0004_4A00_0001, beat 1 = 0x1234_5678_0100_0724.
- Same MRd with `s_axis_tx_tready` low for 3 cycles in TX0 and 2 cycles in TX1 → beats held stable, `m_axis_rx_tready`=0 throughout, `cfg_trn_pending`=1 until TX1 is accepted.
- MRd with length=2, or a 4-beat MWr → `cfg_err_ur` pulses once and all beats are drained. With the macro defined, the MRd case also returns a Cpl with status 001 and beat 1 `tkeep`=0x0F.
- MRd without BAR0 hit → UR handling, and no `reg_rd_en`.
- `sys_rst_n` asserted during TX1 → all outputs return to reset values and the next MRd completes normally.
